// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: sign-magnitude operands, radix-2 shift-add
// multiply and restoring divide, one step per clock, with optional fast exit for DIV/REM corner cases.
module mdu_iterative #(
  parameter int unsigned WIDTH        = 32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         f3;
  logic               neg;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               accept;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               sign_in;
  logic               div_zero, div_ovf, special;
  logic [WIDTH-1:0]   fast_val;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_full;
  logic [WIDTH-1:0]   q_fix, r_fix, fix_val;

  assign accept = (state == IDLE) && start && !flush;
  assign busy   = accept || (state == CALC) || (state == FIX);

  always_comb begin
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg    = a_signed & op_a[WIDTH-1];
    b_neg    = b_signed & op_b[WIDTH-1];
    a_abs    = a_neg ? ('0 - op_a) : op_a;
    b_abs    = b_neg ? ('0 - op_b) : op_b;
    div_zero = funct3[2] && (op_b == '0);
    div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
    special  = div_zero || div_ovf;
    // A zero divisor yields an unsigned all-ones quotient, so the quotient sign is suppressed
    if (!funct3[2])
      sign_in = a_neg ^ b_neg;
    else if (funct3[1])
      sign_in = a_neg;
    else
      sign_in = (a_neg ^ b_neg) && !div_zero;
    if (div_zero)
      fast_val = funct3[1] ? op_a : '1;
    else
      fast_val = funct3[1] ? '0 : op_a;
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    mul_full  = neg ? ('0 - acc) : acc;
    q_fix     = neg ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    r_fix     = neg ? ('0 - rem) : rem;
    if (!f3[2])
      fix_val = (f3[1:0] == 2'b00) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
    else
      fix_val = f3[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      f3     <= '0;
      neg    <= 1'b0;
      b_mag  <= '0;
      acc    <= '0;
      rem    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (accept) begin
            f3    <= funct3;
            neg   <= sign_in;
            b_mag <= b_abs;
            acc   <= {{WIDTH{1'b0}}, a_abs};
            rem   <= '0;
            cnt   <= '0;
            if (FAST_SPECIAL && special) begin
              result <= fast_val;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            // Divide keeps the dividend/quotient in the low half of acc, shifting quotient bits in
            if (f3[2]) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
              rem            <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
              state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            result <= fix_val;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
